// File: rtl/wired_frontend_pkg_queue.sv
// Frontend-to-backend decoupling queue: compacts up to two decoded instructions
// per cycle into program order and offers the oldest two as a masked packet.
package wired_frontend_pkg_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  ctrl;
    } pipeline_ctrl_pack_t;
endpackage

module wired_frontend_pkg_queue
    import wired_frontend_pkg_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [1:0]                in_mask_i,
    input  pipeline_ctrl_pack_t [1:0] in_pkg_i,
    input  logic                      flush_i,
    output logic                      pkg_valid_o,
    input  logic                      pkg_ready_i,
    output logic [1:0]                pkg_mask_o,
    output pipeline_ctrl_pack_t [1:0] pkg_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ROOM2_MAX = CW'(DEPTH - 2);

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

    pipeline_ctrl_pack_t mem_r [DEPTH];
    logic [AW-1:0]       head_r;
    logic [AW-1:0]       tail_r;
    logic [CW-1:0]       count_r;

    logic                enq_fire_s;
    logic                deq_fire_s;
    logic [1:0]          enq_num_s;
    logic [1:0]          deq_num_s;
    logic [AW-1:0]       head_plus1_s;
    logic [AW-1:0]       tail_plus1_s;
    pipeline_ctrl_pack_t wr_first_s;

    // Handshakes: readiness from registered occupancy only, so no path from pkg_ready_i
    always_comb begin
        in_ready_o   = (count_r <= ROOM2_MAX) && !rst;
        pkg_valid_o  = (count_r != CW'(0)) && !flush_i;
        pkg_mask_o   = {count_r >= CW'(2), count_r >= CW'(1)} & {2{!flush_i}};
        enq_fire_s   = in_valid_i && in_ready_o && !flush_i;
        deq_fire_s   = pkg_valid_o && pkg_ready_i;
        enq_num_s    = enq_fire_s ? popcount2(in_mask_i) : 2'd0;
        deq_num_s    = deq_fire_s ? popcount2(pkg_mask_o) : 2'd0;
        head_plus1_s = head_r + AW'(1);
        tail_plus1_s = tail_r + AW'(1);
        // A lone slot-1 instruction compacts down to the tail position
        wr_first_s   = in_mask_i[0] ? in_pkg_i[0] : in_pkg_i[1];
        count_o      = count_r;
    end

    // Outgoing packet, with unmasked slots forced to zero
    always_comb begin
        pkg_o[0] = pkg_mask_o[0] ? mem_r[head_r]       : '0;
        pkg_o[1] = pkg_mask_o[1] ? mem_r[head_plus1_s] : '0;
    end

    // Entry storage; contents are don't-care until covered by count
    always_ff @(posedge clk) begin
        if (enq_fire_s && (in_mask_i != 2'b00)) begin
            mem_r[tail_r] <= wr_first_s;
        end
        if (enq_fire_s && (in_mask_i == 2'b11)) begin
            mem_r[tail_plus1_s] <= in_pkg_i[1];
        end
    end

    // Pointers and occupancy; reset outranks flush, flush outranks traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + AW'(deq_num_s);
            tail_r  <= tail_r + AW'(enq_num_s);
            count_r <= count_r + CW'(enq_num_s) - CW'(deq_num_s);
        end
    end
endmodule

// File: tb/tb_wired_frontend_pkg_queue.sv
// Bench for wired_frontend_pkg_queue: queue-based reference model, directed
// scenarios with literal pins, then randomized traffic with flush and reset.
module tb_wired_frontend_pkg_queue;
    import wired_frontend_pkg_queue_pkg::*;

    localparam int DEPTH = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                in_mask;
    pipeline_ctrl_pack_t [1:0] in_pkg;
    logic                      flush;
    logic                      pkg_valid;
    logic                      pkg_ready;
    logic [1:0]                pkg_mask;
    pipeline_ctrl_pack_t [1:0] pkg;
    logic [3:0]                count;

    always #5 clk = ~clk;

    wired_frontend_pkg_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_mask_i   (in_mask),
        .in_pkg_i    (in_pkg),
        .flush_i     (flush),
        .pkg_valid_o (pkg_valid),
        .pkg_ready_i (pkg_ready),
        .pkg_mask_o  (pkg_mask),
        .pkg_o       (pkg),
        .count_o     (count)
    );

    int vec_n = 0;
    int err_n = 0;

    // Reference: a plain program-order queue of whatever has been accepted
    pipeline_ctrl_pack_t q[$];
    bit model_ok = 1'b0;
    int m_n;
    bit m_deq;
    bit m_enq;

    // Literal expectations armed by the stimulus for the next falling edge
    bit          pin_en = 1'b0;
    int          pin_cnt;
    bit          pin_rdy;
    bit          pin_vld;
    logic [1:0]  pin_msk;
    logic [31:0] pin_pc0;
    logic [31:0] pin_pc1;

    // Advance the reference queue at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            model_ok = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            m_n   = q.size();
            m_deq = (m_n != 0) && pkg_ready;
            m_enq = in_valid && (DEPTH - m_n >= 2);
            if (m_deq) begin
                void'(q.pop_front());
                if (m_n >= 2) void'(q.pop_front());
            end
            if (m_enq) begin
                if (in_mask[0]) q.push_back(in_pkg[0]);
                if (in_mask[1]) q.push_back(in_pkg[1]);
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vec_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    int                  c_n;
    logic [1:0]          e_msk;
    pipeline_ctrl_pack_t e_s0;
    pipeline_ctrl_pack_t e_s1;

    // Compare all DUT outputs against the reference away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            c_n   = q.size();
            e_msk = {c_n >= 2, c_n >= 1} & {2{!flush}};
            e_s0  = '0;
            e_s1  = '0;
            if (e_msk[0]) e_s0 = q[0];
            if (e_msk[1]) e_s1 = q[1];
            chk("count", 128'(count), 128'(c_n));
            chk("in_ready", 128'(in_ready), 128'((DEPTH - c_n >= 2) && !rst));
            chk("pkg_valid", 128'(pkg_valid), 128'((c_n != 0) && !flush));
            chk("pkg_mask", 128'(pkg_mask), 128'(e_msk));
            chk("slot0", 128'(pkg[0]), 128'(e_s0));
            chk("slot1", 128'(pkg[1]), 128'(e_s1));
            if (pin_en) begin
                chk("pin_count", 128'(count), 128'(pin_cnt));
                chk("pin_ready", 128'(in_ready), 128'(pin_rdy));
                chk("pin_valid", 128'(pkg_valid), 128'(pin_vld));
                chk("pin_mask", 128'(pkg_mask), 128'(pin_msk));
                chk("pin_pc0", 128'(pkg[0].pc), 128'(pin_pc0));
                chk("pin_pc1", 128'(pkg[1].pc), 128'(pin_pc1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic pin(input int cnt, input bit rdy, input bit vld, input logic [1:0] msk,
                       input logic [31:0] pc0, input logic [31:0] pc1);
        pin_cnt = cnt;
        pin_rdy = rdy;
        pin_vld = vld;
        pin_msk = msk;
        pin_pc0 = pc0;
        pin_pc1 = pc1;
        pin_en  = 1'b1;
    endtask

    task automatic set_in(input bit v, input logic [1:0] m, input logic [31:0] p0,
                          input logic [31:0] p1, input bit rdy, input bit fl);
        in_valid       = v;
        in_mask        = m;
        in_pkg[0].pc   = p0;
        in_pkg[0].inst = ~p0;
        in_pkg[0].ctrl = p0[7:0] ^ 8'h5a;
        in_pkg[1].pc   = p1;
        in_pkg[1].inst = ~p1;
        in_pkg[1].ctrl = p1[7:0] ^ 8'ha5;
        pkg_ready      = rdy;
        flush          = fl;
    endtask

    initial begin
        int cnt;
        int k;
        rst = 1'b1;
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset held for two edges, then released
        tick();
        pin(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        pin(0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();

        // Lone slot-1 instruction lands at the head
        set_in(1'b1, 2'b10, 32'hdeadbeef, 32'h1c000004, 1'b0, 1'b0);
        pin(0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        pin(1, 1'b1, 1'b1, 2'b01, 32'h1c000004, 32'h0);
        tick();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        pin(1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();

        // Fill to DEPTH, take one pair, refill one: seven entries still block input
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'b11, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i), 1'b0, 1'b0);
            pin(2 * i, 1'b1, i > 0, (i > 0) ? 2'b11 : 2'b00,
                (i > 0) ? 32'h100 : 32'h0, (i > 0) ? 32'h104 : 32'h0);
            tick();
        end
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        pin(8, 1'b0, 1'b1, 2'b11, 32'h100, 32'h104);
        tick();
        set_in(1'b1, 2'b01, 32'h200, 32'h0, 1'b0, 1'b0);
        pin(6, 1'b1, 1'b1, 2'b11, 32'h108, 32'h10c);
        tick();
        set_in(1'b1, 2'b01, 32'h204, 32'h0, 1'b0, 1'b0);
        pin(7, 1'b0, 1'b1, 2'b11, 32'h108, 32'h10c);
        tick();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        pin(7, 1'b0, 1'b1, 2'b11, 32'h108, 32'h10c);
        tick();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        pin(7, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();

        // Offset pointers by one so pair writes and reads straddle index 7 -> 0
        set_in(1'b1, 2'b01, 32'h3c0, 32'h0, 1'b0, 1'b0);
        pin(0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        pin(1, 1'b1, 1'b1, 2'b01, 32'h3c0, 32'h0);
        tick();

        // Ten pcs in pairs, draining two per cycle after a three-cycle lag
        for (int c = 0; c < 9; c++) begin
            cnt = (c < 3) ? 2 * c : ((c < 5) ? 6 : 2 * (8 - c));
            k   = (c >= 3) ? c - 3 : 0;
            if (c < 5) begin
                set_in(1'b1, 2'b11, 32'(8 * c), 32'(8 * c + 4), c >= 3, 1'b0);
            end else begin
                set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
            end
            pin(cnt, 1'b1, cnt != 0, (cnt != 0) ? 2'b11 : 2'b00,
                (cnt != 0) ? 32'(8 * k) : 32'h0, (cnt != 0) ? 32'(8 * k + 4) : 32'h0);
            tick();
        end

        // Enqueue two while taking two at occupancy three
        set_in(1'b1, 2'b11, 32'h400, 32'h404, 1'b0, 1'b0);
        pin(0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        set_in(1'b1, 2'b01, 32'h408, 32'h0, 1'b0, 1'b0);
        pin(2, 1'b1, 1'b1, 2'b11, 32'h400, 32'h404);
        tick();
        set_in(1'b1, 2'b11, 32'h40c, 32'h410, 1'b1, 1'b0);
        pin(3, 1'b1, 1'b1, 2'b11, 32'h400, 32'h404);
        tick();
        set_in(1'b1, 2'b11, 32'h414, 32'h418, 1'b0, 1'b0);
        pin(3, 1'b1, 1'b1, 2'b11, 32'h408, 32'h40c);
        tick();

        // Flush beats a simultaneous enqueue and dequeue at occupancy five
        set_in(1'b1, 2'b11, 32'h500, 32'h504, 1'b1, 1'b1);
        pin(5, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        set_in(1'b1, 2'b01, 32'h600, 32'h0, 1'b0, 1'b0);
        pin(0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        pin(1, 1'b1, 1'b1, 2'b01, 32'h600, 32'h0);
        tick();

        // Randomized traffic with occasional flush and mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mask   = 2'($urandom_range(0, 3));
            pkg_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            for (int s = 0; s < 2; s++) begin
                in_pkg[s].pc   = $urandom();
                in_pkg[s].inst = $urandom();
                in_pkg[s].ctrl = 8'($urandom());
            end
            tick();
        end
        rst = 1'b0;
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end
endmodule
